countdown_timer: RTL

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// countdown_timer: MM:SS.CC countdown with debounced keys, BCD value,
// registered seven-segment outputs and RUN/ALARM/key-level LEDs.
// Optional build macro COUNTDOWN_ALARM_TIMEOUT_EN: ALARM returns to IDLE
// after ALARM_TICKS ticks without a key pulse; otherwise ALARM persists.
module countdown_timer #(
  parameter int COUNTER_10MS    = 500000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ALARM_TICKS     = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_start_pause,
  input  logic       key_load,
  input  logic [5:0] load_minutes,
  input  logic [5:0] load_seconds,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5,
  output logic       led0,
  output logic       led1,
  output logic       led2,
  output logic       led3
);

  localparam int PW = $clog2(COUNTER_10MS + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(COUNTER_10MS - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

  // Value layout: {M1, M0, S1, S0, C1, C0}, one BCD digit per nibble.
  function automatic logic [23:0] bcd_dec(input logic [23:0] v);
    logic [23:0] r;
    r = v;
    if (v[3:0] != 4'd0) r[3:0] = v[3:0] - 4'd1;
    else begin
      r[3:0] = 4'd9;
      if (v[7:4] != 4'd0) r[7:4] = v[7:4] - 4'd1;
      else begin
        r[7:4] = 4'd9;
        if (v[11:8] != 4'd0) r[11:8] = v[11:8] - 4'd1;
        else begin
          r[11:8] = 4'd9;
          if (v[15:12] != 4'd0) r[15:12] = v[15:12] - 4'd1;
          else begin
            r[15:12] = 4'd5;
            if (v[19:16] != 4'd0) r[19:16] = v[19:16] - 4'd1;
            else begin
              r[19:16] = 4'd9;
              r[23:20] = v[23:20] - 4'd1;
            end
          end
        end
      end
    end
    return r;
  endfunction

  // Clamp to 59 and split into tens/units; units computed mod 16 (always < 10).
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [5:0] c;
    logic [3:0] t;
    c = (v > 6'd59) ? 6'd59 : v;
    if      (c >= 6'd50) t = 4'd5;
    else if (c >= 6'd40) t = 4'd4;
    else if (c >= 6'd30) t = 4'd3;
    else if (c >= 6'd20) t = 4'd2;
    else if (c >= 6'd10) t = 4'd1;
    else                 t = 4'd0;
    return {t, c[3:0] - t * 4'd10};
  endfunction

  // Active-low segments, bit0 = a .. bit6 = g.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Index 0 = start/pause key, index 1 = load key.
  logic [1:0]    key_n;
  logic [DW-1:0] db_cnt_q [2];
  logic [1:0]    db_held_q;
  logic [1:0]    db_pulse_q;

  assign key_n = {key_load, key_start_pause};

  // Debounce: pulse once after DEBOUNCE_CYCLES consecutive low samples; re-arm on a high sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) db_cnt_q[k] <= '0;
      db_held_q  <= '0;
      db_pulse_q <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        db_pulse_q[k] <= 1'b0;
        if (key_n[k]) begin
          db_cnt_q[k]  <= '0;
          db_held_q[k] <= 1'b0;
        end else if (!db_held_q[k]) begin
          if (db_cnt_q[k] == DB_LAST) begin
            db_pulse_q[k] <= 1'b1;
            db_held_q[k]  <= 1'b1;
            db_cnt_q[k]   <= '0;
          end else begin
            db_cnt_q[k] <= db_cnt_q[k] + DW'(1);
          end
        end
      end
    end
  end

  logic          start_p, load_p, tick;
  logic [23:0]   load_val, dec_val;
  state_t        state_q, state_d;
  logic [23:0]   val_q, val_d;
  logic [PW-1:0] presc_q, presc_d;

  assign start_p  = db_pulse_q[0];
  assign load_p   = db_pulse_q[1];
  assign load_val = {to_bcd(load_minutes), to_bcd(load_seconds), 8'h00};

`ifdef COUNTDOWN_ALARM_TIMEOUT_EN
  localparam int AW = $clog2(ALARM_TICKS + 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);
  logic [AW-1:0] atmr_q, atmr_d;
`endif

  // Next-state logic: key pulses, prescaler tick, BCD decrement and alarm handling.
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    presc_d = presc_q;
    dec_val = bcd_dec(val_q);
    tick    = (presc_q == PRESC_LAST);
`ifdef COUNTDOWN_ALARM_TIMEOUT_EN
    atmr_d  = '0;
`endif
    case (state_q)
      IDLE: begin
        if (load_p) val_d = load_val;
        else if (start_p && (val_q != 24'd0)) begin
          state_d = RUN;
          presc_d = '0;
        end
      end
      RUN: begin
        // Pause beats a coincident tick; load is ignored while running.
        if (start_p) state_d = PAUSE;
        else if (tick) begin
          presc_d = '0;
          val_d   = dec_val;
          if (dec_val == 24'd0) state_d = ALARM;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      PAUSE: begin
        if (load_p) begin
          val_d   = load_val;
          state_d = IDLE;
        end else if (start_p) begin
          state_d = RUN;
          presc_d = '0;
        end
      end
      ALARM: begin
        if (load_p) begin
          val_d   = load_val;
          state_d = IDLE;
        end else if (start_p) begin
          val_d   = 24'd0;
          state_d = IDLE;
        end
`ifdef COUNTDOWN_ALARM_TIMEOUT_EN
        else if (tick) begin
          presc_d = '0;
          if (atmr_q == ALARM_LAST) begin
            state_d = IDLE;
            val_d   = 24'd0;
          end else begin
            atmr_d = atmr_q + AW'(1);
          end
        end else begin
          presc_d = presc_q + PW'(1);
          atmr_d  = atmr_q;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State, value and prescaler registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      val_q   <= '0;
      presc_q <= '0;
`ifdef COUNTDOWN_ALARM_TIMEOUT_EN
      atmr_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      presc_q <= presc_d;
`ifdef COUNTDOWN_ALARM_TIMEOUT_EN
      atmr_q  <= atmr_d;
`endif
    end
  end

  logic [6:0] hex_q [6];

  // Registered segment decode, one cycle behind the value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 6; k++) hex_q[k] <= 7'b1000000;
    end else begin
      for (int k = 0; k < 6; k++) hex_q[k] <= seg7(val_q[4*k +: 4]);
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];
  assign led0 = (state_q == RUN);
  assign led1 = (state_q == ALARM);
  assign led2 = db_held_q[0];
  assign led3 = db_held_q[1];

endmodule
